// File: rtl/bist_sequencer.sv
// Built-in self-test sequencer: clears the signature analyzer, seeds the LFSR, runs one
// frame of pixel pulses, lets the pipeline settle, then compares the signature to golden.
//
// state  | meaning
// IDLE   | waiting for start, all control outputs low
// CLEAR  | one-cycle signature analyzer clear
// SEED   | one-cycle LFSR seed load
// RUN    | LFSR and analyzer enabled, counting pixel pulses, idle timer armed
// SETTLE | analyzer still enabled for the pipeline tail, LFSR stopped
// CHECK  | frame_done pulse, signature compared against golden
// DONE   | results held until restart or abort
module bist_sequencer #(
   parameter int DATA_W   = 24,
   parameter int FRAME_PX = 16,
   parameter int TIMEOUT  = 255,
   parameter int SETTLE   = 2
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             start_i,
   input  logic                             abort_i,
   input  logic [DATA_W-1:0]                seed_i,
   input  logic [DATA_W-1:0]                golden_i,
   input  logic                             px_rdy_i,
   input  logic [DATA_W-1:0]                signature_i,
   output logic                             sa_clear_o,
   output logic                             sa_en_o,
   output logic                             seed_load_o,
   output logic                             seed_rdy_o,
   output logic [DATA_W-1:0]                seed_data_o,
   output logic                             lfsr_en_o,
   output logic                             frame_done_o,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             pass_o,
   output logic                             timeout_o,
   output logic [$clog2(FRAME_PX+1)-1:0]    px_count_o
);

   localparam int PXW = $clog2(FRAME_PX + 1);
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int SW  = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SEED,
      S_RUN,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] golden_q;
   logic [TW-1:0]     timer_q;
   logic [SW-1:0]     settle_q;
   logic              start_acc;
   logic              px_hit;
   logic              last_px;
   logic              tmo_hit;
   logic              settle_end;

   always_comb begin
      state_nxt  = state;
      start_acc  = 1'b0;
      px_hit     = (state == S_RUN) && px_rdy_i;
      last_px    = px_hit && (px_count_o == PXW'(FRAME_PX - 1));
      // A pixel on the expiry cycle wins, so the timer only fires on an idle cycle.
      tmo_hit    = (state == S_RUN) && !px_rdy_i && (timer_q == TW'(TIMEOUT - 1));
      settle_end = (settle_q == SW'(SETTLE - 1));
      case (state)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               start_acc = 1'b1;
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR:  state_nxt = S_SEED;
         S_SEED:   state_nxt = S_RUN;
         S_RUN: begin
            if (last_px)      state_nxt = S_SETTLE;
            else if (tmo_hit) state_nxt = S_DONE;
         end
         S_SETTLE: if (settle_end) state_nxt = S_CHECK;
         S_CHECK:  state_nxt = S_DONE;
         default:  state_nxt = S_IDLE;
      endcase
      if (abort_i) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state        <= S_IDLE;
         sa_clear_o   <= 1'b0;
         sa_en_o      <= 1'b0;
         seed_load_o  <= 1'b0;
         seed_rdy_o   <= 1'b0;
         seed_data_o  <= '0;
         lfsr_en_o    <= 1'b0;
         frame_done_o <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         pass_o       <= 1'b0;
         timeout_o    <= 1'b0;
         px_count_o   <= '0;
         golden_q     <= '0;
         timer_q      <= '0;
         settle_q     <= '0;
      end else begin
         state <= state_nxt;
         // Control outputs are decoded from the next state so they line up with it.
         sa_clear_o   <= (state_nxt == S_CLEAR);
         seed_load_o  <= (state_nxt == S_SEED);
         seed_rdy_o   <= (state_nxt == S_SEED);
         lfsr_en_o    <= (state_nxt == S_RUN);
         sa_en_o      <= (state_nxt == S_RUN) || (state_nxt == S_SETTLE);
         frame_done_o <= (state_nxt == S_CHECK);
         busy_o       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
         done_o       <= (state_nxt == S_DONE);

         if ((state == S_RUN) && !px_rdy_i && (state_nxt == S_RUN))
            timer_q <= timer_q + 1'b1;
         else
            timer_q <= '0;

         if ((state == S_SETTLE) && (state_nxt == S_SETTLE))
            settle_q <= settle_q + 1'b1;
         else
            settle_q <= '0;

         if (abort_i) begin
            seed_data_o <= '0;
            golden_q    <= '0;
            px_count_o  <= '0;
            pass_o      <= 1'b0;
            timeout_o   <= 1'b0;
         end else begin
            if (start_acc) begin
               seed_data_o <= seed_i;
               golden_q    <= golden_i;
               px_count_o  <= '0;
               pass_o      <= 1'b0;
               timeout_o   <= 1'b0;
            end
            if (px_hit && (px_count_o != PXW'(FRAME_PX)))
               px_count_o <= px_count_o + 1'b1;
            if (tmo_hit)
               timeout_o <= 1'b1;
            if (state == S_CHECK)
               pass_o <= (signature_i == golden_q);
         end
      end
   end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: a small LFSR/signature-analyzer model reacts to the
// DUT controls, and a scoreboard of per-test expectations is checked when done_o rises.
module tb_bist_sequencer;

   localparam int DW = 24;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [DW-1:0] seed_i = '0;
   logic [DW-1:0] golden_i = '0;
   logic          px_rdy_i = 1'b0;
   logic [DW-1:0] signature_i;
   logic          sa_clear_o, sa_en_o, seed_load_o, seed_rdy_o, lfsr_en_o, frame_done_o;
   logic          busy_o, done_o, pass_o, timeout_o;
   logic [DW-1:0] seed_data_o;
   logic [4:0]    px_count_o;

   bist_sequencer dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .seed_i       (seed_i),
      .golden_i     (golden_i),
      .px_rdy_i     (px_rdy_i),
      .signature_i  (signature_i),
      .sa_clear_o   (sa_clear_o),
      .sa_en_o      (sa_en_o),
      .seed_load_o  (seed_load_o),
      .seed_rdy_o   (seed_rdy_o),
      .seed_data_o  (seed_data_o),
      .lfsr_en_o    (lfsr_en_o),
      .frame_done_o (frame_done_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .pass_o       (pass_o),
      .timeout_o    (timeout_o),
      .px_count_o   (px_count_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic          pass;
      logic          tmo;
      logic [7:0]    px;
      logic [7:0]    fd;
      logic [7:0]    clr;
      logic [7:0]    sd;
      logic [DW-1:0] seed;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] lfsr_adv(input logic [DW-1:0] x);
      return {x[DW-2:0], x[23] ^ x[22] ^ x[21] ^ x[16]};
   endfunction

   function automatic logic [DW-1:0] sig_step(input logic [DW-1:0] s, input logic [DW-1:0] l);
      return {s[DW-2:0], s[DW-1]} ^ l;
   endfunction

   function automatic logic [DW-1:0] sig_of(input logic [DW-1:0] seed, input int n);
      logic [DW-1:0] s = '0;
      logic [DW-1:0] l = seed;
      for (int i = 0; i < n; i++) begin
         s = sig_step(s, l);
         l = lfsr_adv(l);
      end
      return s;
   endfunction

   // Environment model: LFSR feeding a rotating signature analyzer.
   logic [DW-1:0] lfsr_m = '0;
   logic [DW-1:0] sig_m = '0;
   assign signature_i = sig_m;

   always @(posedge clk_i) begin
      if (reset_i || sa_clear_o) sig_m <= '0;
      else if (sa_en_o && px_rdy_i) sig_m <= sig_step(sig_m, lfsr_m);
      if (seed_load_o && seed_rdy_o) lfsr_m <= seed_data_o;
      else if (lfsr_en_o && px_rdy_i) lfsr_m <= lfsr_adv(lfsr_m);
   end

   function automatic logic [9:0] outs();
      return {sa_clear_o, sa_en_o, seed_load_o, seed_rdy_o, lfsr_en_o,
              frame_done_o, busy_o, done_o, pass_o, timeout_o};
   endfunction

   // Monitor: per-test pulse counts, scoreboard pop on rising done_o.
   logic          busy_q = 1'b0, done_q = 1'b0;
   int            fd_n = 0, clr_n = 0, sd_n = 0;
   logic [DW-1:0] seed_seen = '0;

   always begin
      exp_t e;
      @(posedge clk_i);
      #2;
      if (busy_o && !busy_q) begin
         fd_n = 0; clr_n = 0; sd_n = 0;
      end
      if (frame_done_o) fd_n++;
      if (sa_clear_o) clr_n++;
      if (seed_load_o && seed_rdy_o) begin
         sd_n++;
         seed_seen = seed_data_o;
      end
      if (done_o && !done_q) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pass", pass_o, e.pass);
            chk("timeout", timeout_o, e.tmo);
            chk("px_count", px_count_o, e.px);
            chk("frame_done_cnt", fd_n, e.fd);
            chk("clear_cnt", clr_n, e.clr);
            chk("seed_cnt", sd_n, e.sd);
            chk("seed_data", seed_seen, e.seed);
         end
      end
      busy_q = busy_o;
      done_q = done_o;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_run();
      int n = 0;
      while (!lfsr_en_o && n < 20) begin
         step();
         n++;
      end
      chk("wait_run", lfsr_en_o, 1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         step();
         n++;
      end
      chk("wait_done", done_o, 1);
   endtask

   task automatic send_px(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         px_rdy_i = 1'b1;
         step();
         px_rdy_i = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic start_pulse(input logic [DW-1:0] seed, input logic [DW-1:0] golden);
      seed_i   = seed;
      golden_i = golden;
      start_i  = 1'b1;
      step();
      start_i  = 1'b0;
   endtask

   initial begin
      int n;

      // Reset state
      repeat (3) step();
      chk("reset_outs", outs(), 0);
      chk("reset_px", px_count_o, 0);
      chk("reset_seed", seed_data_o, 0);
      reset_i = 1'b0;

      // Pass case, started on the first cycle after reset release
      sb.push_back('{1'b1, 1'b0, 8'd16, 8'd1, 8'd1, 8'd1, 24'h00ACE1});
      start_pulse(24'h00ACE1, sig_of(24'h00ACE1, 16));
      chk("clear_pulse", {busy_o, sa_clear_o}, 2'b11);
      step();
      chk("seed_pulse", {sa_clear_o, seed_load_o, seed_rdy_o}, 3'b011);
      wait_run();
      send_px(15, 2);
      px_rdy_i = 1'b1;
      step();
      px_rdy_i = 1'b0;
      chk("settle_en", {lfsr_en_o, sa_en_o}, 2'b01);
      n = 0;
      while (!frame_done_o && n < 10) begin
         step();
         n++;
      end
      chk("settle_len", n, 2);
      wait_done(10);

      // Mismatch case, with one ignored pulse during SETTLE
      sb.push_back('{1'b0, 1'b0, 8'd16, 8'd1, 8'd1, 8'd1, 24'h123456});
      start_pulse(24'h123456, 24'hFFFFFF);
      wait_run();
      send_px(16, 1);
      px_rdy_i = 1'b1;
      step();
      px_rdy_i = 1'b0;
      wait_done(10);

      // Timeout after 5 pulses
      sb.push_back('{1'b0, 1'b1, 8'd5, 8'd0, 8'd1, 8'd1, 24'h0F0F0F});
      start_pulse(24'h0F0F0F, 24'h0);
      wait_run();
      send_px(5, 0);
      n = 0;
      while (!done_o && n < 400) begin
         step();
         n++;
      end
      chk("timeout_latency", n, 255);

      // Abort in RUN at px_count=8
      start_pulse(24'h55AA55, 24'h0);
      wait_run();
      send_px(8, 0);
      chk("abort_px8", px_count_o, 8);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("abort_outs", outs(), 0);
      chk("abort_px", px_count_o, 0);
      chk("abort_seed", seed_data_o, 0);

      // Reset in RUN, with abort and start also asserted
      start_pulse(24'h55AA55, 24'h0);
      wait_run();
      send_px(8, 0);
      chk("reset_px8", px_count_o, 8);
      reset_i  = 1'b1;
      abort_i  = 1'b1;
      start_i  = 1'b1;
      seed_i   = 24'hBEEF01;
      golden_i = sig_of(24'hBEEF01, 16);
      step();
      chk("midreset_outs", outs(), 0);
      chk("midreset_px", px_count_o, 0);
      chk("midreset_seed", seed_data_o, 0);
      abort_i = 1'b0;
      step();
      sb.push_back('{1'b1, 1'b0, 8'd16, 8'd1, 8'd1, 8'd1, 24'hBEEF01});
      reset_i = 1'b0;
      step();
      chk("restart_first", {busy_o, sa_clear_o}, 2'b11);
      start_i = 1'b0;
      wait_run();
      send_px(16, 1);
      wait_done(20);

      // start held through a whole test: no retrigger while busy, restart from DONE
      sb.push_back('{1'b1, 1'b0, 8'd16, 8'd1, 8'd1, 8'd1, 24'h0000A5});
      seed_i   = 24'h0000A5;
      golden_i = sig_of(24'h0000A5, 16);
      start_i  = 1'b1;
      step();
      wait_run();
      send_px(16, 0);
      wait_done(20);
      step();
      chk("held_restart", {done_o, busy_o, sa_clear_o, pass_o}, 4'b0110);
      start_i = 1'b0;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;

      // px_rdy on the timer-expiry cycle wins
      sb.push_back('{1'b1, 1'b0, 8'd16, 8'd1, 8'd1, 8'd1, 24'h3C3C3C});
      start_pulse(24'h3C3C3C, sig_of(24'h3C3C3C, 16));
      wait_run();
      send_px(3, 0);
      repeat (254) step();
      px_rdy_i = 1'b1;
      step();
      px_rdy_i = 1'b0;
      chk("collide_px", px_count_o, 4);
      chk("collide_no_tmo", {done_o, timeout_o, lfsr_en_o}, 3'b001);
      send_px(12, 0);
      wait_done(20);

      repeat (3) step();
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, the width of the seed, golden and signature words.
REQ-002 SHALL have parameter FRAME_PX, default 16, the output pixel pulses per test frame (legal range >= 1).
REQ-003 SHALL have parameter TIMEOUT, default 255, the idle cycles allowed between pixel pulses in RUN (legal range >= 1).
REQ-004 SHALL have parameter SETTLE, default 2, the cycles held after the last pixel before the check (legal range >= 1).
REQ-005 clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 reset_i  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  level; start a test when idle or done.
REQ-008 abort_i  in  1  level; cancel the test from any state.
REQ-009 seed_i  in  DATA_W  LFSR seed; latched when a test starts.
REQ-010 golden_i  in  DATA_W  expected signature; latched when a test starts.
REQ-011 px_rdy_i  in  1  one-cycle pulse per datapath output pixel.
REQ-012 signature_i  in  DATA_W  signature analyzer output.
REQ-013 sa_clear_o  out  1  signature analyzer clear pulse.
REQ-014 sa_en_o  out  1  signature analyzer enable.
REQ-015 seed_load_o  out  1  LFSR configuration select.
REQ-016 seed_rdy_o  out  1  LFSR configuration data valid.
REQ-017 seed_data_o  out  DATA_W  latched seed.
REQ-018 lfsr_en_o  out  1  LFSR run enable.
REQ-019 frame_done_o  out  1  end-of-frame pulse.
REQ-020 busy_o, done_o, pass_o, timeout_o  out  1 each  status flags.
REQ-021 px_count_o  out  clog2(FRAME_PX+1)  pixels counted in the current test.

Function
REQ-022 The FSM SHALL have the states IDLE, CLEAR, SEED, RUN, SETTLE, CHECK and DONE; all outputs SHALL be registered.
REQ-023 IDLE: all control outputs are 0; start_i=1 SHALL latch seed_i and golden_i, clear px_count, and go to CLEAR on the next cycle.
REQ-024 CLEAR: sa_clear_o=1 for exactly one cycle, then go to SEED.
REQ-025 SEED: seed_load_o=1 and seed_rdy_o=1 for exactly one cycle with seed_data_o valid, then go to RUN.
REQ-026 RUN: lfsr_en_o=1 and sa_en_o=1; each px_rdy_i pulse SHALL increment px_count_o (saturating at FRAME_PX).
REQ-027 RUN exit: the cycle on which the count reaches FRAME_PX SHALL cause entry to SETTLE on the next cycle.
REQ-028 SETTLE: lfsr_en_o=0 and sa_en_o=1 for SETTLE cycles, then go to CHECK.
REQ-029 The timeout timer SHALL count RUN cycles without px_rdy_i and SHALL reload to 0 on any px_rdy_i.
REQ-030 Timeout: when the timer reaches TIMEOUT, the FSM SHALL go to DONE with timeout_o=1 and pass_o=0, skipping SETTLE and CHECK.
REQ-031 Simultaneous px_rdy_i and timer expiry: px_rdy_i SHALL win; the pulse is counted and there is no timeout.
REQ-032 CHECK: frame_done_o=1 for one cycle; the block SHALL sample signature_i, set pass_o=(signature_i==golden latch), then go to DONE.
REQ-033 DONE: done_o=1, and pass_o, timeout_o and px_count_o are held.
REQ-034 Restart from DONE: start_i=1 SHALL clear done_o, pass_o and timeout_o, relatch the inputs, and go to CLEAR.
REQ-035 busy_o SHALL be 1 in CLEAR through CHECK; start_i SHALL be ignored while busy_o=1.
REQ-036 px_rdy_i SHALL be ignored outside RUN and SETTLE; pulses in SETTLE are not counted.
REQ-037 abort_i SHALL force IDLE on the next cycle from any state, clearing all status outputs and px_count_o.
REQ-038 abort_i SHALL take priority over start_i, timeout and all state transitions.

Reset
REQ-039 reset_i=1 at a clock edge SHALL force IDLE and drive every output, latch, counter and timer to 0.
REQ-040 Reset SHALL take priority over abort_i and start_i, including when asserted mid-test.
REQ-041 The first cycle after reset release SHALL accept start_i.

Verification
REQ-042 Pass case: seed=0x00ACE1, golden=signature model value, 16 px_rdy pulses -> sa_clear, seed pulse, lfsr_en for 16 pulses, frame_done, then done=1, pass=1, px_count=16.
REQ-043 Mismatch case: golden=0xFFFFFF with a model signature != 0xFFFFFF -> done=1, pass=0, timeout=0.
REQ-044 Timeout case: px_rdy stops after 5 pulses -> done=1 exactly 255 cycles after the last pulse, timeout=1, px_count=5, no frame_done pulse.
REQ-045 Abort and reset in RUN: abort at px_count=8 -> IDLE next cycle with all outputs 0; repeat with reset_i instead -> same result; a following start -> clean test.
REQ-046 Collisions: start held through a whole test -> no retrigger while busy, restart from DONE; px_rdy on the timer-expiry cycle -> counted, no timeout.
